ecc_27_rd_chk: RTL and testbench
================================

# ecc_27_rd_chk

Registered, flow-controlled SEC-DED check stage for the read side of the ECC-protected FIFO. It sits directly downstream of the FIFO RAM read port. It takes each stored 27-bit data word with its 7-bit check field, corrects single-bit errors, and flags uncorrectable words. It also maintains saturating error counters and a first-error syndrome capture for software/debug.

## Interface
- `DATA_WIDTH`, 27, data word width (fixed by the 27/7 code; other values unsupported)
- `PARITY_WIDTH`, 7, check field width
- `CNT_WIDTH`, 16, width of each error counter
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  RAM read word valid
- `in_ready`  out  1  stage can accept a word this cycle
- `in_data`  in  27  raw stored data
- `in_parity`  in  7  stored check bits
- `in_bypass`  in  1  per-word: skip correction/flagging, qualified by `in_valid`
- `out_valid`  out  1  corrected word valid
- `out_ready`  in  1  consumer accepts
- `out_data`  out  27  corrected (or bypassed) data
- `out_sbit`  out  1  word had a correctable error, incl. check-bit-only error
- `out_dbit`  out  1  word had an uncorrectable error; data passed uncorrected
- `clr_err`  in  1  synchronous pulse: clear counters, capture and sticky flag
- `sbit_cnt`  out  CNT_WIDTH  saturating count of words with `out_sbit`
- `dbit_cnt`  out  CNT_WIDTH  saturating count of words with `out_dbit`
- `dbit_irq`  out  1  sticky, set by any uncorrectable word
- `err_vld`  out  1  capture register holds a syndrome
- `err_syndrome`  out  7  syndrome of first erroneous word since last clear

## Operation
- Two-stage pipeline.
  - Stage A registers `{in_data, in_parity, in_bypass}`.
  - Stage B registers the decoder outputs from the existing 27/7 decode cell `ecc_27_cal`, driven from stage A: `out_data`, `out_sbit`, `out_dbit`.
- Stage B also registers the syndrome, computed as `stageA_parity ^ encode(stageA_data)`.
- Handshake (valid/ready, no combinational valid→valid paths):
  - `b_ready = !out_valid | out_ready`
  - `in_ready = !a_vld | b_ready`
  - A word transfers on `valid & ready` at each boundary.
  - `out_valid` never drops without `out_ready`; `out_data`/flags stay stable while stalled.
- Bypass words: `out_data = in_data`, `out_sbit = out_dbit = 0`, no counter or capture update.
- Counter/capture updates happen only on an A→B transfer.
  - `sbit_cnt` increments on sbit; `dbit_cnt` increments on dbit.
  - Each counter saturates at all-ones and does not wrap.
- Capture: on the first sbit or dbit while `err_vld = 0`, load `err_syndrome` and set `err_vld`. Later errors do not overwrite it.
- `dbit_irq` sets on any dbit transfer and holds until `clr_err`.
- `clr_err` in the same cycle as an error transfer: clear wins (counters → 0, `err_vld`/`dbit_irq` → 0). That word is not counted.

## Timing
- Reset values: `in_ready = 1` (combinational from empty pipe); all of the following are 0:
  - `out_valid`, `out_data`, `out_sbit`, `out_dbit`
  - `sbit_cnt`, `dbit_cnt`, `dbit_irq`, `err_vld`, `err_syndrome`
- Latency: word accepted in cycle N appears with `out_valid = 1` in cycle N+2 when unstalled.
- Throughput: one word per cycle with `out_ready` held high.
- Full pipe with `out_ready = 0`: `in_ready = 0`. When `out_ready` rises, `in_ready` rises in the same cycle.
- Simultaneous output pop and input push on a full pipe: both complete; no bubble.
- Reset asserted mid-stream: in-flight words are discarded, outputs go to reset values immediately (async), counters clear.
- `clr_err` takes effect on the next clock edge; it does not affect data flow.

## Configuration
- `ECC27_ERR_CAPTURE_EN` defined: syndrome register, `err_vld` and `err_syndrome` are implemented as above.
- Not defined: no syndrome logic or capture flops. `err_vld` and `err_syndrome` are tied to 0. Counters, `dbit_irq` and data path are unchanged.

## Test plan
- Clean word: data 27'h0000000, parity 7'h00, `out_ready = 1` → two cycles later `out_data = 0`, sbit/dbit 0, counters 0.
- Single data error: data 27'h0000001, parity 7'h00 → `out_data = 0`, `out_sbit = 1`, `sbit_cnt = 1`, `err_syndrome = 7'b1000011`, `err_vld = 1`.
- Check-bit error then double error:
  - data 0, parity 7'h01 → data 0, sbit.
  - Next, data 27'h4000001, parity 0 → `out_data = 27'h4000001`, `out_dbit = 1`, `dbit_irq = 1`.
  - `err_syndrome` stays 7'b0000001.
- Backpressure: stream 4 words with `out_ready = 0` for 5 cycles → `in_ready` low after 2 accepted; release → all 4 words emerge in order, none lost or duplicated.
- Saturation/clear: with `CNT_WIDTH = 2`, inject 5 sbit words → `sbit_cnt = 3`. `clr_err` coincident with a dbit transfer → `dbit_cnt = 0`, `dbit_irq = 0`.
- Bypass and reset:
  - Bypass word with data 27'h1, parity 0 → `out_data = 1`, no flags, no count.
  - Assert `rst_n` low while 2 words are in flight → `out_valid = 0` immediately; no stale word after release.

Source files
------------

// File: rtl/ecc_27_rd_chk.sv
// Two-stage SEC-DED (27 data / 7 check) read-side checker with error counters and irq.
// Optional first-error syndrome capture is built when ECC27_ERR_CAPTURE_EN is defined.

package ecc_27_pkg;

  // Check-bit column of data bit idx: Hamming position, topped with the overall-parity bit so that every column has odd weight.
  function automatic logic [6:0] ecc_col(input int idx);
    logic [5:0] pos;
    int         n;
    pos = 6'd0;
    n   = 0;
    for (int k = 3; k < 34; k++) begin
      if ((k & (k - 1)) != 0) begin
        if (n == idx) begin
          pos = 6'(k);
        end
        n++;
      end
    end
    return {~^pos, pos};
  endfunction

  function automatic logic [6:0] ecc_enc(input logic [26:0] d);
    logic [6:0] p;
    p = 7'd0;
    for (int i = 0; i < 27; i++) begin
      p = p ^ (d[i] ? ecc_col(i) : 7'd0);
    end
    return p;
  endfunction

endpackage

module ecc_27_cal (
  input  logic [26:0] data,
  input  logic [6:0]  parity,
  output logic [26:0] data_o,
  output logic        sbit,
  output logic        dbit
);

  logic [6:0]  syn;
  logic [26:0] fix;
  logic        hit;

  // Syndrome decode: odd weight matching a column is correctable, anything else non-zero is not.
  always_comb begin
    syn = parity ^ ecc_27_pkg::ecc_enc(data);
    fix = 27'd0;
    for (int i = 0; i < 27; i++) begin
      fix[i] = (syn == ecc_27_pkg::ecc_col(i));
    end
    hit = (|fix) | ((syn & (syn - 7'd1)) == 7'd0);
    if (syn == 7'd0) begin
      data_o = data;
      sbit   = 1'b0;
      dbit   = 1'b0;
    end else if ((^syn) && hit) begin
      data_o = data ^ fix;
      sbit   = 1'b1;
      dbit   = 1'b0;
    end else begin
      data_o = data;
      sbit   = 1'b0;
      dbit   = 1'b1;
    end
  end

endmodule

module ecc_27_rd_chk #(
  parameter int DATA_WIDTH   = 27,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [PARITY_WIDTH-1:0] in_parity,
  input  logic                    in_bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_sbit,
  output logic                    out_dbit,
  input  logic                    clr_err,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  output logic                    dbit_irq,
  output logic                    err_vld,
  output logic [PARITY_WIDTH-1:0] err_syndrome
);

  logic                    a_vld_q, a_vld_d, a_bypass_q, a_bypass_d;
  logic [DATA_WIDTH-1:0]   a_data_q, a_data_d;
  logic [PARITY_WIDTH-1:0] a_parity_q, a_parity_d;
  logic                    out_valid_q, out_valid_d, out_sbit_q, out_sbit_d, out_dbit_q, out_dbit_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic                    dbit_irq_q, dbit_irq_d;
  logic                    b_ready, in_fire, a_to_b, sbit_ev, dbit_ev;
  logic [DATA_WIDTH-1:0]   dec_data;
  logic                    dec_sbit, dec_dbit;

  ecc_27_cal u_cal (
    .data   (a_data_q),
    .parity (a_parity_q),
    .data_o (dec_data),
    .sbit   (dec_sbit),
    .dbit   (dec_dbit)
  );

  // Handshake, pipeline next-state and saturating error bookkeeping.
  always_comb begin
    b_ready  = !out_valid_q | out_ready;
    in_ready = !a_vld_q | b_ready;
    in_fire  = in_valid & in_ready;
    a_to_b   = a_vld_q & b_ready;
    sbit_ev  = a_to_b & !a_bypass_q & dec_sbit;
    dbit_ev  = a_to_b & !a_bypass_q & dec_dbit;

    a_vld_d    = a_vld_q;
    a_data_d   = a_data_q;
    a_parity_d = a_parity_q;
    a_bypass_d = a_bypass_q;
    if (in_fire) begin
      a_vld_d    = 1'b1;
      a_data_d   = in_data;
      a_parity_d = in_parity;
      a_bypass_d = in_bypass;
    end else if (a_to_b) begin
      a_vld_d = 1'b0;
    end else begin
      a_vld_d = a_vld_q;
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sbit_d  = out_sbit_q;
    out_dbit_d  = out_dbit_q;
    if (a_to_b) begin
      out_valid_d = 1'b1;
      out_data_d  = a_bypass_q ? a_data_q : dec_data;
      out_sbit_d  = !a_bypass_q & dec_sbit;
      out_dbit_d  = !a_bypass_q & dec_dbit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    sbit_cnt_d = sbit_cnt_q;
    dbit_cnt_d = dbit_cnt_q;
    dbit_irq_d = dbit_irq_q;
    if (clr_err) begin
      sbit_cnt_d = {CNT_WIDTH{1'b0}};
      dbit_cnt_d = {CNT_WIDTH{1'b0}};
      dbit_irq_d = 1'b0;
    end else begin
      if (sbit_ev && (sbit_cnt_q != {CNT_WIDTH{1'b1}})) begin
        sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
      end else begin
        sbit_cnt_d = sbit_cnt_q;
      end
      if (dbit_ev && (dbit_cnt_q != {CNT_WIDTH{1'b1}})) begin
        dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
      end else begin
        dbit_cnt_d = dbit_cnt_q;
      end
      dbit_irq_d = dbit_irq_q | dbit_ev;
    end
  end

  // Pipeline and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q     <= 1'b0;
      a_data_q    <= {DATA_WIDTH{1'b0}};
      a_parity_q  <= {PARITY_WIDTH{1'b0}};
      a_bypass_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_WIDTH{1'b0}};
      out_sbit_q  <= 1'b0;
      out_dbit_q  <= 1'b0;
      sbit_cnt_q  <= {CNT_WIDTH{1'b0}};
      dbit_cnt_q  <= {CNT_WIDTH{1'b0}};
      dbit_irq_q  <= 1'b0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_data_q    <= a_data_d;
      a_parity_q  <= a_parity_d;
      a_bypass_q  <= a_bypass_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sbit_q  <= out_sbit_d;
      out_dbit_q  <= out_dbit_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      dbit_irq_q  <= dbit_irq_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sbit  = out_sbit_q;
  assign out_dbit  = out_dbit_q;
  assign sbit_cnt  = sbit_cnt_q;
  assign dbit_cnt  = dbit_cnt_q;
  assign dbit_irq  = dbit_irq_q;

`ifdef ECC27_ERR_CAPTURE_EN
  logic                    err_vld_q, err_vld_d;
  logic [PARITY_WIDTH-1:0] err_syn_q, err_syn_d;

  // First-error capture; a clear in the same cycle wins over a load.
  always_comb begin
    err_vld_d = err_vld_q;
    err_syn_d = err_syn_q;
    if (clr_err) begin
      err_vld_d = 1'b0;
      err_syn_d = {PARITY_WIDTH{1'b0}};
    end else if ((sbit_ev || dbit_ev) && !err_vld_q) begin
      err_vld_d = 1'b1;
      err_syn_d = a_parity_q ^ ecc_27_pkg::ecc_enc(a_data_q);
    end else begin
      err_vld_d = err_vld_q;
    end
  end

  // Capture state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld_q <= 1'b0;
      err_syn_q <= {PARITY_WIDTH{1'b0}};
    end else begin
      err_vld_q <= err_vld_d;
      err_syn_q <= err_syn_d;
    end
  end

  assign err_vld      = err_vld_q;
  assign err_syndrome = err_syn_q;
`else
  assign err_vld      = 1'b0;
  assign err_syndrome = {PARITY_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_ecc_27_rd_chk.sv
// Self-checking bench for ecc_27_rd_chk: directed cases plus randomized traffic against an
// extended-Hamming reference model that decodes by brute-force nearest-codeword search.
module tb_ecc_27_rd_chk;

  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_bypass, out_ready, clr_err;
  logic [26:0]   in_data;
  logic [6:0]    in_parity;
  logic          in_ready, out_valid, out_sbit, out_dbit, dbit_irq, err_vld;
  logic [26:0]   out_data;
  logic [6:0]    err_syndrome;
  logic [CW-1:0] sbit_cnt, dbit_cnt;

  ecc_27_rd_chk #(.DATA_WIDTH(27), .PARITY_WIDTH(7), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_parity(in_parity), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sbit(out_sbit), .out_dbit(out_dbit), .clr_err(clr_err),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .dbit_irq(dbit_irq),
    .err_vld(err_vld), .err_syndrome(err_syndrome)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [26:0] data;
    logic        sbit, dbit, cnt_en, lat_en;
    logic [6:0]  syn;
    int          acc_cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0, n_bad = 0, cyc = 0, m_sc = 0, m_dc = 0;
  logic       m_irq = 1'b0, m_vld = 1'b0, acc = 1'b0, lat_en = 1'b0, nocnt = 1'b0;
  logic [6:0] m_syn = 7'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Data sits at Hamming positions 3,5,6,7,9..; p[j] covers positions with bit j set; p[6] is overall parity.
  function automatic logic [6:0] ref_enc(input logic [26:0] d);
    logic [33:0] cw;
    logic [6:0]  p;
    int          n;
    cw = '0; p = '0; n = 0;
    for (int q = 1; q <= 33; q++) if ((q & (q - 1)) != 0) begin cw[q] = d[n]; n++; end
    for (int j = 0; j < 6; j++)
      for (int q = 1; q <= 33; q++) if (((q >> j) & 1) == 1) p[j] = p[j] ^ cw[q];
    p[6] = (^d) ^ (^p[5:0]);
    return p;
  endfunction

  task automatic ref_dec(input logic [26:0] d, input logic [6:0] p,
                         output logic [26:0] od, output logic os, output logic odb);
    logic [33:0] w, f;
    od = d; os = 1'b0; odb = 1'b0;
    if (p != ref_enc(d)) begin
      w = {p, d};
      odb = 1'b1;
      for (int j = 0; j < 34; j++) begin
        f = w; f[j] = ~f[j];
        if (f[33:27] == ref_enc(f[26:0])) begin od = f[26:0]; os = 1'b1; odb = 1'b0; end
      end
    end
  endtask

  task automatic clear_model();
    m_sc = 0; m_dc = 0; m_irq = 1'b0; m_vld = 1'b0; m_syn = 7'd0;
  endtask

  task automatic step();
    exp_t e;
    logic exp_vld;
    logic [6:0] exp_syn;
    @(negedge clk);
    cyc++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("pop_empty", {31'd0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data", {5'd0, out_data}, {5'd0, e.data});
        chk("sbit", {31'd0, out_sbit}, {31'd0, e.sbit});
        chk("dbit", {31'd0, out_dbit}, {31'd0, e.dbit});
        if (e.cnt_en) begin
          if (e.sbit && m_sc < MAXC) m_sc++;
          if (e.dbit && m_dc < MAXC) m_dc++;
          if (e.dbit) m_irq = 1'b1;
          if ((e.sbit || e.dbit) && !m_vld) begin m_vld = 1'b1; m_syn = e.syn; end
        end
`ifdef ECC27_ERR_CAPTURE_EN
        exp_vld = m_vld; exp_syn = m_syn;
`else
        exp_vld = 1'b0; exp_syn = 7'd0;
`endif
        chk("sbit_cnt", {30'd0, sbit_cnt}, m_sc);
        chk("dbit_cnt", {30'd0, dbit_cnt}, m_dc);
        chk("dbit_irq", {31'd0, dbit_irq}, {31'd0, m_irq});
        chk("err_vld", {31'd0, err_vld}, {31'd0, exp_vld});
        chk("err_syn", {25'd0, err_syndrome}, {25'd0, exp_syn});
        if (e.lat_en) chk("latency", cyc - e.acc_cyc, 32'd2);
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e.acc_cyc = cyc; e.lat_en = lat_en; e.cnt_en = !nocnt;
      e.syn = in_parity ^ ref_enc(in_data);
      if (in_bypass) begin e.data = in_data; e.sbit = 1'b0; e.dbit = 1'b0; end
      else ref_dec(in_data, in_parity, e.data, e.sbit, e.dbit);
      sb.push_back(e);
    end
    @(posedge clk);
    if (clr_err) clear_model();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() > 0; i++) step();
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic send(input logic [26:0] d, input logic [6:0] p, input logic b);
    in_valid = 1'b1; in_data = d; in_parity = p; in_bypass = b;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step();
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; step(); clr_err = 1'b0;
  endtask

  // Random word with 0, 1 or 2 flipped codeword bits.
  task automatic rand_word(input int nerr, output logic [26:0] d, output logic [6:0] p);
    logic [33:0] w;
    int i, j;
    d = 27'($urandom());
    w = {ref_enc(d), d};
    i = $urandom_range(0, 33);
    j = (i + 1 + $urandom_range(0, 32)) % 34;
    if (nerr >= 1) w[i] = ~w[i];
    if (nerr >= 2) w[j] = ~w[j];
    d = w[26:0]; p = w[33:27];
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [26:0] d, bw[4];
    logic [6:0]  p, bp[4];
    int k;
    logic exp_v;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 27'd0; in_parity = 7'd0;
    in_bypass = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {5'd0, out_data}, 32'd0);
    chk("rst_flags", {30'd0, out_sbit, out_dbit}, 32'd0);
    chk("rst_cnts", {28'd0, sbit_cnt, dbit_cnt}, 32'd0);
    chk("rst_irq_vld", {30'd0, dbit_irq, err_vld}, 32'd0);
    chk("rst_syn", {25'd0, err_syndrome}, 32'd0);
    rst_n = 1'b1;

    lat_en = 1'b1;
    send(27'd0, 7'h00, 1'b0);
    chk("clean_cnt", {28'd0, sbit_cnt, dbit_cnt}, 32'd0);
    send(27'h0000001, 7'h00, 1'b0);
    chk("sbe_cnt", {30'd0, sbit_cnt}, 32'd1);
`ifdef ECC27_ERR_CAPTURE_EN
    chk("sbe_syn", {24'd0, err_vld, err_syndrome}, {24'd0, 1'b1, 7'b1000011});
`endif
    pulse_clr();
    send(27'd0, 7'h01, 1'b0);
    send(27'h4000001, 7'h00, 1'b0);
    chk("dbe_irq", {31'd0, dbit_irq}, 32'd1);
    chk("dbe_cnts", {28'd0, sbit_cnt, dbit_cnt}, {28'd0, 2'd1, 2'd1});
`ifdef ECC27_ERR_CAPTURE_EN
    chk("dbe_syn_kept", {25'd0, err_syndrome}, {25'd0, 7'b0000001});
`endif
    send(27'h0000001, 7'h00, 1'b1);
    chk("bypass_cnts", {28'd0, sbit_cnt, dbit_cnt}, {28'd0, 2'd1, 2'd1});
    lat_en = 1'b0;

    // Backpressure: four words, consumer stalled for five cycles.
    for (int i = 0; i < 4; i++) rand_word(i % 3, bw[i], bp[i]);
    out_ready = 1'b0; k = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = bw[k]; in_parity = bp[k]; in_bypass = 1'b0;
      step();
      if (acc) k++;
    end
    chk("bp_accepted", k, 32'd2);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 20 && k < 4; c++) begin
      in_data = bw[k]; in_parity = bp[k];
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    chk("bp_all_sent", k, 32'd4);
    drain();

    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      d = 27'($urandom());
      p = ref_enc(d);
      d[$urandom_range(0, 26)] ^= 1'b1;
      send(d, p, 1'b0);
    end
    chk("sat_sbit", {30'd0, sbit_cnt}, 32'd3);

    send(27'h4000001, 7'h00, 1'b0);
    chk("pre_clr_dbit", {30'd0, dbit_cnt}, 32'd1);
    in_valid = 1'b1; in_data = 27'h4000001; in_parity = 7'h00; in_bypass = 1'b0;
    nocnt = 1'b1; step(); nocnt = 1'b0;
    in_valid = 1'b0; clr_err = 1'b1; step(); clr_err = 1'b0;
    drain();
    chk("clr_wins_cnt", {30'd0, dbit_cnt}, 32'd0);
    chk("clr_wins_irq", {30'd0, dbit_irq, err_vld}, 32'd0);

    // Back-to-back throughput.
    for (int i = 0; i < 8; i++) begin
      rand_word(i % 3, d, p);
      in_valid = 1'b1; in_data = d; in_parity = p; in_bypass = 1'b0;
      #1;
      chk("thru_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0;
    drain();

    for (int c = 0; c < 400; c++) begin
      rand_word($urandom_range(0, 2), d, p);
      in_valid = ($urandom_range(0, 3) != 0); in_data = d; in_parity = p;
      in_bypass = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with two words in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_word(1, d, p);
      in_valid = 1'b1; in_data = d; in_parity = p; in_bypass = 1'b0;
      step();
    end
    in_valid = 1'b0;
    chk("rst_inflight", {31'd0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_cnts", {29'd0, sbit_cnt, dbit_irq}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    clear_model();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    exp_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_v = exp_v | out_valid;
    end
    chk("no_stale", {31'd0, exp_v}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
